// File: rtl/gshare_spec_predictor.sv
// gshare_spec_predictor: gshare predictor with speculative GHR, snapshot repair, init sweep and stats
module gshare_spec_predictor #(
    parameter int HIST_BITS  = 8,
    parameter int INDEX_BITS = 10,
    parameter int PC_LSB     = 2,
    parameter int CTR_BITS   = 2,
    parameter int INIT_CTR   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  predict_req,
    input  logic [31:0]           pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [CTR_BITS-1:0]   pred_ctr,
    output logic [HIST_BITS-1:0]  pred_ghr,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic [HIST_BITS-1:0]  update_ghr,
    input  logic                  update_taken,
    input  logic                  update_predicted,
    output logic                  mispredict,
    output logic [HIST_BITS-1:0]  ghr_out,
    output logic [31:0]           update_count,
    output logic [31:0]           mispredict_count
);
    typedef enum logic {S_INIT, S_READY} state_t;
    state_t state, state_next;
    logic [INDEX_BITS-1:0] ptr, p_idx, u_idx;
    logic [CTR_BITS-1:0] pht [2**INDEX_BITS];
    logic [CTR_BITS-1:0] p_ctr, u_ctr, u_next;
    logic [HIST_BITS-1:0] ghr, ghr_next;
    logic p_dir, accept_p, accept_u;
    logic unused_bits;
    assign unused_bits = ^{pc, update_pc};
    assign ready = state == S_READY;
    assign accept_p = ready & predict_req;
    assign accept_u = ready & update_valid;
    assign mispredict = accept_u & (update_taken != update_predicted);
    assign ghr_out = ghr;
    assign p_idx = pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
    assign u_idx = update_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(update_ghr);
    assign p_ctr = pht[p_idx];
    assign p_dir = p_ctr[CTR_BITS-1];
    assign u_ctr = pht[u_idx];
    always_comb begin
        state_next = (state == S_INIT && ptr == '1) ? S_READY : state;
        u_next = update_taken ? ((u_ctr == '1) ? u_ctr : u_ctr + 1'b1)
                              : ((u_ctr == '0) ? u_ctr : u_ctr - 1'b1);
        // repair from the resolved snapshot overrides this cycle's speculative shift
        ghr_next = mispredict ? {update_ghr[HIST_BITS-2:0], update_taken}
                 : accept_p   ? {ghr[HIST_BITS-2:0], p_dir} : ghr;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_INIT;
            ptr              <= '0;
            ghr              <= '0;
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            pred_ctr         <= '0;
            pred_ghr         <= '0;
            update_count     <= '0;
            mispredict_count <= '0;
        end else begin
            state      <= state_next;
            ghr        <= ghr_next;
            pred_valid <= accept_p;
            if (state == S_INIT) ptr <= ptr + 1'b1;
            if (accept_p) begin
                pred_taken <= p_dir;
                pred_ctr   <= p_ctr;
                pred_ghr   <= ghr;
            end
            if (accept_u && update_count != '1) update_count <= update_count + 32'd1;
            if (mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (state == S_INIT) pht[ptr] <= CTR_BITS'(INIT_CTR);
        else if (accept_u) pht[u_idx] <= u_next;
    end
endmodule

// File: tb/tb_gshare_spec_predictor.sv
// tb_gshare_spec_predictor: scoreboard bench against a table-level reference model
module tb_gshare_spec_predictor;
    logic clk = 0, rst = 1;
    logic ready, predict_req = 0, pred_valid, pred_taken, mispredict;
    logic [31:0] pc = 0, update_pc = 0, update_count, mispredict_count;
    logic [1:0] pred_ctr;
    logic [7:0] pred_ghr, update_ghr = 0, ghr_out;
    logic update_valid = 0, update_taken = 0, update_predicted = 0;
    int checks = 0, errors = 0;
    typedef struct {int ctr; int taken; int ghr;} exp_t;
    exp_t sb[$];
    int m_pht [1024];
    int m_ghr, m_upd, m_mis;

    gshare_spec_predictor dut (
        .clk(clk), .rst(rst), .ready(ready), .predict_req(predict_req), .pc(pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr), .pred_ghr(pred_ghr),
        .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
        .update_taken(update_taken), .update_predicted(update_predicted), .mispredict(mispredict),
        .ghr_out(ghr_out), .update_count(update_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (pred_valid) begin
            if (sb.size() == 0) chk("unexpected_pred_valid", 32'(pred_valid), 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("pred_ctr", 32'(pred_ctr), 32'(e.ctr));
                chk("pred_taken", 32'(pred_taken), 32'(e.taken));
                chk("pred_ghr", 32'(pred_ghr), 32'(e.ghr));
            end
        end
    end

    function automatic int tbl(logic [31:0] p, int h);
        return ((p / 4) % 1024) ^ h;
    endfunction

    task automatic model_reset();
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr = 0; m_upd = 0; m_mis = 0;
    endtask

    // one clock cycle while ready: drive, model the edge, check post-edge state
    task automatic step(bit pr, logic [31:0] p, bit uv, logic [31:0] up, int ug, bit ut, bit upr);
        int c, t, ui, nghr;
        bit miss;
        predict_req = pr; pc = p; update_valid = uv; update_pc = up;
        update_ghr = 8'(ug); update_taken = ut; update_predicted = upr;
        #1;
        miss = uv && (ut != upr);
        chk("mispredict", 32'(mispredict), 32'(miss));
        nghr = m_ghr;
        if (pr) begin
            c = m_pht[tbl(p, m_ghr)];
            t = c >= 2 ? 1 : 0;
            sb.push_back('{c, t, m_ghr});
            nghr = ((m_ghr * 2) + t) % 256;
        end
        if (uv) begin
            ui = tbl(up, ug);
            m_pht[ui] = ut ? (m_pht[ui] < 3 ? m_pht[ui] + 1 : 3) : (m_pht[ui] > 0 ? m_pht[ui] - 1 : 0);
            m_upd++;
            if (miss) begin
                m_mis++;
                nghr = ((ug * 2) + ut) % 256;
            end
        end
        m_ghr = nghr;
        @(posedge clk); #1;
        predict_req = 0; update_valid = 0;
        chk("ghr_out", 32'(ghr_out), 32'(m_ghr));
        chk("update_count", update_count, 32'(m_upd));
        chk("mispredict_count", mispredict_count, 32'(m_mis));
        chk("ready", 32'(ready), 32'd1);
    endtask

    task automatic reset_and_sweep();
        int n;
        rst = 1; predict_req = 0; update_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_ctr", 32'(pred_ctr), 32'd0);
        chk("rst_pred_ghr", 32'(pred_ghr), 32'd0);
        chk("rst_ghr", 32'(ghr_out), 32'd0);
        chk("rst_upd_cnt", update_count, 32'd0);
        chk("rst_mis_cnt", mispredict_count, 32'd0);
        n = 0;
        while (!ready && n < 2000) begin
            predict_req = (n == 500); pc = 32'h100;
            n++;
            @(posedge clk); #1;
            if (n == 501) chk("init_req_ignored", 32'(pred_valid), 32'd0);
        end
        predict_req = 0;
        chk("init_cycles", 32'(n), 32'd1024);
    endtask

    initial begin
        rst = 1;
        @(posedge clk); #1;
        reset_and_sweep();
        step(1, 32'h100, 0, 0, 0, 0, 0);
        chk("t2_ghr", 32'(ghr_out), 32'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h100, 0, 1, 1);
        step(1, 32'h100, 0, 0, 0, 0, 0);
        chk("t3_ghr", 32'(ghr_out), 32'h01);
        chk("t3_upd", update_count, 32'd3);
        chk("t3_mis", mispredict_count, 32'd0);
        step(0, 0, 1, 32'h300, 8'h5A, 1, 0);
        chk("t4_ghr", 32'(ghr_out), 32'hB5);
        chk("t4_mis", mispredict_count, 32'd1);
        step(0, 0, 1, 32'h304, 8'h07, 1, 0);
        chk("t5_pre_ghr", 32'(ghr_out), 32'h0F);
        step(1, 32'h13C, 1, 32'h200, 8'h03, 0, 1);
        chk("t5_ghr", 32'(ghr_out), 32'h06);
        for (int i = 0; i < 1500; i++)
            step(1'($urandom), 32'($urandom_range(0, 15)) * 4, 1'($urandom),
                 32'($urandom_range(0, 15)) * 4, int'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom));
        @(negedge clk); #1;
        reset_and_sweep();
        for (int i = 0; i < 1024; i++) step(1, 32'(i) * 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++)
            step(1'($urandom), $urandom, 1'($urandom), $urandom, int'($urandom_range(0, 255)),
                 1'($urandom), 1'($urandom));
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
